// File: rtl/conv_lsu_bridge.sv
`default_nettype none
// ============================================================================
//  Module   : conv_lsu_bridge
//  Purpose  : Read-side responder between the convolution accelerator's LSU
//             port and the core data-memory port. Buffers fire-and-forget
//             accelerator reads, replays them with an accept/ack handshake
//             and returns read data in request order.
//  Revision : 1.0  initial release
// ============================================================================
module conv_lsu_bridge #(
    parameter int REQ_DEPTH       = 8,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        acc_rd_i,
    input  logic [31:0] acc_addr_i,
    output logic        acc_ack_o,
    output logic [31:0] acc_data_o,
    output logic        mem_rd_o,
    output logic [31:0] mem_addr_o,
    input  logic        mem_accept_i,
    input  logic        mem_ack_i,
    input  logic [31:0] mem_data_i,
    input  logic        mem_error_i,
    input  logic        flush_i,
    input  logic        clear_i,
    output logic        busy_o,
    output logic        overflow_o,
    output logic        error_o
);

    localparam int PTR_W = $clog2(REQ_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int OUT_W = 4;
    localparam logic [CNT_W-1:0] DEPTH_C   = CNT_W'(REQ_DEPTH);
    localparam logic [OUT_W-1:0] MAX_OUT_C = OUT_W'(MAX_OUTSTANDING);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_DRAIN  = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;

    logic [31:0]      fifo_mem [REQ_DEPTH];
    logic [31:0]      head_addr;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_next;
    logic [OUT_W-1:0] outstanding;
    logic [OUT_W-1:0] outstanding_next;
    logic [OUT_W-1:0] discard_cnt;
    logic [OUT_W-1:0] discard_next;

    logic             fifo_empty;
    logic             fifo_full;
    logic             pop;
    logic             push;
    logic             push_drop;
    logic             ack_counted;
    logic             ack_discard;

    assign fifo_empty  = (count == '0);
    assign fifo_full   = (count == DEPTH_C);
    assign head_addr   = fifo_mem[rd_ptr];

    // Issue is held off while stale responses are still being drained, and
    // a flush cancels the request in the very cycle it is raised.
    assign mem_rd_o    = !fifo_empty && (outstanding < MAX_OUT_C) &&
                         (discard_cnt == '0) && !flush_i;
    assign mem_addr_o  = fifo_empty ? 32'h0 : (head_addr & 32'hFFFF_FFFC);

    assign pop         = mem_rd_o && mem_accept_i;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign push        = acc_rd_i && !flush_i && (!fifo_full || pop);
    assign push_drop   = acc_rd_i && !flush_i && fifo_full && !pop;
    assign ack_counted = mem_ack_i && (discard_cnt == '0);
    assign ack_discard = mem_ack_i && (discard_cnt != '0);

    assign busy_o      = (state != ST_IDLE);

    // Next FIFO occupancy; flush empties it regardless of push/pop.
    always_comb begin
        count_next = count;
        if (flush_i) begin
            count_next = '0;
        end else if (push && !pop) begin
            count_next = count + 1'b1;
        end else if (!push && pop) begin
            count_next = count - 1'b1;
        end
    end

    // In-flight bookkeeping; on flush every in-flight read becomes a discard.
    always_comb begin
        outstanding_next = outstanding;
        discard_next     = discard_cnt;
        if (pop && !ack_counted) begin
            outstanding_next = outstanding + 1'b1;
        end else if (!pop && ack_counted) begin
            outstanding_next = outstanding - 1'b1;
        end
        if (ack_discard) begin
            discard_next = discard_cnt - 1'b1;
        end
        if (flush_i) begin
            discard_next     = discard_next + outstanding_next;
            outstanding_next = '0;
        end
    end

    // Next-state logic for the IDLE / ACTIVE / DRAIN controller.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (push) begin
                    state_next = ST_ACTIVE;
                end
            end
            ST_ACTIVE: begin
                if (flush_i) begin
                    state_next = (discard_next != '0) ? ST_DRAIN : ST_IDLE;
                end else if ((count_next == '0) && (outstanding_next == '0)) begin
                    state_next = ST_IDLE;
                end
            end
            ST_DRAIN: begin
                if (discard_next == '0) begin
                    state_next = (count_next != '0) ? ST_ACTIVE : ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Controller state register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Request storage; contents are only meaningful below the count.
    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_mem[wr_ptr] <= acc_addr_i;
        end
    end

    // FIFO pointers, occupancy, outstanding and discard counters.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            outstanding <= '0;
            discard_cnt <= '0;
        end else begin
            count       <= count_next;
            outstanding <= outstanding_next;
            discard_cnt <= discard_next;
            if (flush_i) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (push) begin
                    wr_ptr <= wr_ptr + 1'b1;
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + 1'b1;
                end
            end
        end
    end

    // Response path: one-cycle ack pulse; errored responses return zero data.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            acc_ack_o  <= 1'b0;
            acc_data_o <= 32'h0;
        end else begin
            acc_ack_o <= ack_counted;
            if (ack_counted) begin
                acc_data_o <= mem_error_i ? 32'h0 : mem_data_i;
            end
        end
    end

    // Sticky flags; a new event in the clear cycle keeps the flag set.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            overflow_o <= 1'b0;
            error_o    <= 1'b0;
        end else begin
            if (push_drop) begin
                overflow_o <= 1'b1;
            end else if (clear_i) begin
                overflow_o <= 1'b0;
            end
            if (ack_counted && mem_error_i) begin
                error_o <= 1'b1;
            end else if (clear_i) begin
                error_o <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_conv_lsu_bridge.sv
`default_nettype none
// ============================================================================
//  Module   : tb_conv_lsu_bridge
//  Purpose  : Scoreboard bench for conv_lsu_bridge with a behavioural memory
//             responder (data = word address, programmable ack delay/error).
//  Revision : 1.0  initial release
// ============================================================================
module tb_conv_lsu_bridge;

    localparam int REQ_DEPTH       = 8;
    localparam int MAX_OUTSTANDING = 4;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        acc_rd_i;
    logic [31:0] acc_addr_i;
    logic        acc_ack_o;
    logic [31:0] acc_data_o;
    logic        mem_rd_o;
    logic [31:0] mem_addr_o;
    logic        mem_accept_i;
    logic        mem_ack_i;
    logic [31:0] mem_data_i;
    logic        mem_error_i;
    logic        flush_i;
    logic        clear_i;
    logic        busy_o;
    logic        overflow_o;
    logic        error_o;

    conv_lsu_bridge #(
        .REQ_DEPTH       (REQ_DEPTH),
        .MAX_OUTSTANDING (MAX_OUTSTANDING)
    ) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .acc_rd_i     (acc_rd_i),
        .acc_addr_i   (acc_addr_i),
        .acc_ack_o    (acc_ack_o),
        .acc_data_o   (acc_data_o),
        .mem_rd_o     (mem_rd_o),
        .mem_addr_o   (mem_addr_o),
        .mem_accept_i (mem_accept_i),
        .mem_ack_i    (mem_ack_i),
        .mem_data_i   (mem_data_i),
        .mem_error_i  (mem_error_i),
        .flush_i      (flush_i),
        .clear_i      (clear_i),
        .busy_o       (busy_o),
        .overflow_o   (overflow_o),
        .error_o      (error_o)
    );

    initial forever #5 clk_i = ~clk_i;

    int cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    int          checks_total  = 0;
    int          checks_passed = 0;
    logic [31:0] exp_q[$];
    int          ack_total = 0;
    int          ack_cyc[512];

    // Memory responder controls
    logic        accept_en    = 1'b1;
    int          ack_delay    = 1;
    logic [31:0] err_addr     = 32'hFFFF_FFFF;
    bit          cap_mode     = 1'b0;
    int          max_inflight = 0;
    logic [31:0] watch_addr   = 32'hFFFF_FFFF;
    int          watch_gap    = -1;
    int          last_ack_cyc = 0;

    typedef struct {
        int          due;
        logic [31:0] addr;
    } resp_t;
    resp_t pend_q[$];

    assign mem_accept_i = accept_en;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks_total++;
        if (actual === expected) checks_passed++;
        else $display("FAIL %s: actual=%h required=%h (t=%0t)", name, actual, expected, $time);
    endtask

    // Scoreboard monitor: every ack pulse must match the oldest expected word.
    initial begin : monitor
        logic [31:0] e;
        forever begin
            @(negedge clk_i);
            if (!rst_i && acc_ack_o) begin
                if (ack_total < 512) ack_cyc[ack_total] = cyc;
                ack_total++;
                if (exp_q.size() == 0) begin
                    checks_total++;
                    $display("FAIL unexpected_ack: actual data=%h required=no ack (t=%0t)", acc_data_o, $time);
                end else begin
                    e = exp_q.pop_front();
                    check("ack_data", acc_data_o, e);
                end
            end
        end
    end

    // Memory responder: acks each accepted request ack_delay cycles later.
    initial begin : mem_model
        resp_t r;
        mem_ack_i   = 1'b0;
        mem_data_i  = 32'h0;
        mem_error_i = 1'b0;
        forever begin
            @(posedge clk_i);
            #1;
            mem_ack_i   = 1'b0;
            mem_data_i  = 32'h0;
            mem_error_i = 1'b0;
            if (pend_q.size() > 0 && pend_q[0].due <= cyc) begin
                r = pend_q.pop_front();
                mem_ack_i    = 1'b1;
                mem_data_i   = r.addr;
                mem_error_i  = (r.addr == err_addr);
                last_ack_cyc = cyc;
            end
            @(negedge clk_i);
            if (rst_i) begin
                pend_q.delete();
            end else begin
                if (cap_mode && (pend_q.size() + int'(mem_ack_i)) >= MAX_OUTSTANDING)
                    check("cap_hold_rd", {31'b0, mem_rd_o}, 32'h0);
                if (mem_rd_o && mem_accept_i) begin
                    pend_q.push_back('{cyc + ack_delay, mem_addr_o});
                    if (pend_q.size() > max_inflight) max_inflight = pend_q.size();
                    if (mem_addr_o == watch_addr) watch_gap = cyc - last_ack_cyc;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic send(input logic [31:0] a, input bit expect_resp, input logic [31:0] exp_data);
        acc_rd_i   = 1'b1;
        acc_addr_i = a;
        if (expect_resp) exp_q.push_back(exp_data);
        tick();
        acc_rd_i   = 1'b0;
    endtask

    task automatic wait_drain(input string name, input int budget);
        for (int i = 0; i < budget && exp_q.size() != 0; i++) tick();
        check(name, exp_q.size(), 0);
    endtask

    task automatic pulse_clear();
        clear_i = 1'b1;
        tick();
        clear_i = 1'b0;
    endtask

    task automatic run_stream(input string tag);
        int b;
        int req_cyc;
        b = ack_total;
        req_cyc = cyc;
        for (int i = 0; i < 20; i++) send(32'h1000 + 32'(4 * i), 1'b1, 32'h1000 + 32'(4 * i));
        wait_drain({tag, "_drain"}, 200);
        repeat (3) tick();
        check({tag, "_ack_count"}, 32'(ack_total - b), 20);
        check({tag, "_first_latency"}, 32'(ack_cyc[b] - req_cyc), 3);
        check({tag, "_throughput"}, 32'(ack_cyc[b + 19] - ack_cyc[b]), 19);
        check({tag, "_overflow"}, {31'b0, overflow_o}, 32'h0);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: actual=timeout required=completion");
        $fatal(1, "bench timeout");
    end

    initial begin : stimulus
        int b;
        rst_i      = 1'b1;
        acc_rd_i   = 1'b0;
        acc_addr_i = 32'h0;
        flush_i    = 1'b0;
        clear_i    = 1'b0;
        repeat (3) @(posedge clk_i);
        #1;
        check("rst_acc_ack",  {31'b0, acc_ack_o},  32'h0);
        check("rst_acc_data", acc_data_o,          32'h0);
        check("rst_mem_rd",   {31'b0, mem_rd_o},   32'h0);
        check("rst_mem_addr", mem_addr_o,          32'h0);
        check("rst_busy",     {31'b0, busy_o},     32'h0);
        check("rst_overflow", {31'b0, overflow_o}, 32'h0);
        check("rst_error",    {31'b0, error_o},    32'h0);
        rst_i = 1'b0;
        tick();

        // Streaming with a zero-wait memory
        run_stream("stream1");

        // Error on the second response; unaligned addresses are word-masked
        err_addr = 32'h2004;
        send(32'h2001, 1'b1, 32'h2000);
        send(32'h2006, 1'b1, 32'h0);
        send(32'h200B, 1'b1, 32'h2008);
        send(32'h200C, 1'b1, 32'h200C);
        wait_drain("err_drain", 100);
        check("err_flag_set", {31'b0, error_o}, 32'h1);
        check("err_no_overflow", {31'b0, overflow_o}, 32'h0);
        pulse_clear();
        check("err_flag_cleared", {31'b0, error_o}, 32'h0);
        err_addr = 32'hFFFF_FFFF;

        // Backpressure: 10 reads into an 8-deep FIFO while accept is low
        accept_en = 1'b0;
        b = ack_total;
        for (int i = 0; i < 10; i++) send(32'h5000 + 32'(4 * i), (i < 8), 32'h5000 + 32'(4 * i));
        repeat (2) tick();
        check("bp_overflow_set", {31'b0, overflow_o}, 32'h1);
        check("bp_rd_held", {31'b0, mem_rd_o}, 32'h1);
        check("bp_addr_held", mem_addr_o, 32'h5000);
        accept_en = 1'b1;
        wait_drain("bp_drain", 100);
        repeat (3) tick();
        check("bp_ack_count", 32'(ack_total - b), 8);
        check("bp_overflow_sticky", {31'b0, overflow_o}, 32'h1);
        pulse_clear();
        check("bp_overflow_cleared", {31'b0, overflow_o}, 32'h0);

        // Outstanding cap with slow acks
        max_inflight = 0;
        ack_delay    = 10;
        cap_mode     = 1'b1;
        for (int i = 0; i < 10; i++) send(32'h7000 + 32'(4 * i), 1'b1, 32'h7000 + 32'(4 * i));
        wait_drain("cap_drain", 300);
        cap_mode = 1'b0;
        check("cap_max_inflight", 32'(max_inflight), 4);

        // Flush with 3 in flight and 5 queued, then a read during DRAIN
        ack_delay = 20;
        send(32'h4000, 1'b0, 32'h0);
        send(32'h4004, 1'b0, 32'h0);
        send(32'h4008, 1'b0, 32'h0);
        tick();
        accept_en = 1'b0;
        for (int i = 0; i < 5; i++) send(32'h4010 + 32'(4 * i), 1'b0, 32'h0);
        flush_i    = 1'b1;
        acc_rd_i   = 1'b1;
        acc_addr_i = 32'h4040;
        tick();
        flush_i   = 1'b0;
        acc_rd_i  = 1'b0;
        accept_en = 1'b1;
        check("flush_busy", {31'b0, busy_o}, 32'h1);
        check("flush_fifo_empty_rd", {31'b0, mem_rd_o}, 32'h0);
        ack_delay  = 1;
        watch_addr = 32'h3000;
        send(32'h3000, 1'b1, 32'h3000);
        repeat (2) tick();
        check("drain_no_issue", {31'b0, mem_rd_o}, 32'h0);
        check("drain_busy", {31'b0, busy_o}, 32'h1);
        wait_drain("drain_drain", 100);
        check("drain_issue_gap", 32'(watch_gap), 1);
        repeat (2) tick();
        check("drain_idle", {31'b0, busy_o}, 32'h0);
        check("flush_no_overflow", {31'b0, overflow_o}, 32'h0);
        watch_addr = 32'hFFFF_FFFF;

        // Asynchronous reset with the FIFO half full
        accept_en = 1'b0;
        for (int i = 0; i < 4; i++) send(32'h6000 + 32'(4 * i), 1'b0, 32'h0);
        check("pre_rst_rd", {31'b0, mem_rd_o}, 32'h1);
        #3;
        rst_i = 1'b1;
        #1;
        check("arst_acc_ack",  {31'b0, acc_ack_o},  32'h0);
        check("arst_acc_data", acc_data_o,          32'h0);
        check("arst_mem_rd",   {31'b0, mem_rd_o},   32'h0);
        check("arst_mem_addr", mem_addr_o,          32'h0);
        check("arst_busy",     {31'b0, busy_o},     32'h0);
        check("arst_overflow", {31'b0, overflow_o}, 32'h0);
        check("arst_error",    {31'b0, error_o},    32'h0);
        repeat (2) @(posedge clk_i);
        #1;
        rst_i     = 1'b0;
        accept_en = 1'b1;
        tick();
        run_stream("stream2");

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/conv_lsu_bridge.md
# conv_lsu_bridge

Read-side responder for the convolution accelerator's LSU port. It accepts the accelerator's fire-and-forget word reads (one per cycle, no stall signal on that side) and buffers them in a request FIFO. It replays them onto the core's data-memory port using the accept/ack handshake, and returns read data to the accelerator in request order. It sits between the accelerator and the memory arbiter in the execute/LSU cluster.

## Interface
Parameters:
- REQ_DEPTH, 8, request FIFO entries (power of two, ≥2)
- MAX_OUTSTANDING, 4, maximum accepted-but-unacknowledged memory reads (1..15)

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset, asynchronous, active-high
- acc_rd_i  in  1  accelerator read request, one word per asserted cycle
- acc_addr_i  in  32  accelerator byte address
- acc_ack_o  out  1  read data valid to accelerator, single-cycle pulse
- acc_data_o  out  32  read data
- mem_rd_o  out  1  memory read request
- mem_addr_o  out  32  memory word address, bits [1:0] forced to 0
- mem_accept_i  in  1  memory accepted the current request
- mem_ack_i  in  1  memory response valid
- mem_data_i  in  32  memory response data
- mem_error_i  in  1  response error, qualified by mem_ack_i
- flush_i  in  1  abort: drop queued requests, discard in-flight responses
- clear_i  in  1  clear sticky flags
- busy_o  out  1  state != IDLE
- overflow_o  out  1  sticky: a request was dropped because the FIFO was full
- error_o  out  1  sticky: a response had mem_error_i set

## Operation
- FIFO: push on acc_rd_i, storing acc_addr_i. Pop on mem_rd_o && mem_accept_i.
  - Push while full is dropped and sets overflow_o, unless a pop occurs in the same cycle. In that case the push is accepted.
  - Count is $clog2(REQ_DEPTH)+1 bits. Pointers wrap modulo REQ_DEPTH.
- Issue: mem_rd_o = FIFO non-empty && outstanding < MAX_OUTSTANDING && discard_cnt == 0 && !flush_i. mem_addr_o = {head[31:2],2'b00}. A request holds stable until accepted.
- Outstanding counter: +1 on accept, −1 on a counted ack. Both in the same cycle → unchanged.
- Response: on mem_ack_i with discard_cnt == 0:
  - acc_ack_o <= 1 and acc_data_o <= mem_data_i, next cycle.
  - If mem_error_i: acc_data_o <= 0 and error_o set. The ack is still returned so the accelerator's word count completes.
- Flush (flush_i high for one cycle):
  - FIFO emptied. A push in the same cycle is discarded and does not set overflow.
  - discard_cnt <= outstanding, plus 1 if an accept happened that cycle.
  - Responses arriving while discard_cnt > 0 decrement discard_cnt and produce no acc_ack_o.
- States:
  - IDLE: FIFO empty, outstanding = 0, discard_cnt = 0. Go to ACTIVE on an accepted push.
  - ACTIVE: go to DRAIN on flush_i with outstanding+accept > 0. Go to IDLE on flush otherwise, or when FIFO empty and outstanding = 0.
  - DRAIN: requests may be enqueued but are not issued. Exit when discard_cnt reaches 0: to ACTIVE if FIFO non-empty, else IDLE.
- Sticky flags: clear_i clears overflow_o and error_o. A set in the same cycle as clear_i wins.

## Timing
- Reset values: acc_ack_o=0, acc_data_o=0, mem_rd_o=0, mem_addr_o=0, busy_o=0, overflow_o=0, error_o=0. FIFO, outstanding and discard_cnt are all 0.
- Reset mid-transaction drops everything. Late mem_ack_i after reset release is discarded only if discard_cnt was nonzero. Since discard_cnt is reset, the memory side must also be reset together.
- FIFO is registered: push at cycle N → earliest mem_rd_o at N+1.
- mem_ack_i at cycle M → acc_ack_o at M+1.
- Zero-wait memory (accept same cycle, ack next cycle): acc_rd_i at 0 → acc_ack_o at 3.
- Throughput with an unstalled memory: 1 word/cycle.
- busy_o is combinational from the state register.
- mem_rd_o depends combinationally on flush_i. It has no combinational path from mem_accept_i or mem_ack_i.

## Test plan
- Streaming: 20 back-to-back reads at 0x1000+4i, zero-wait memory returning data = address → 20 acc_ack_o pulses with data 0x1000..0x104C in order, first ack 3 cycles after first request, overflow_o=0.
- Backpressure: mem_accept_i low for 12 cycles while 10 reads arrive (REQ_DEPTH=8) → 8 retained, 2 dropped, overflow_o=1. After release, exactly 8 acks return in order. clear_i → overflow_o=0.
- Outstanding cap: accept always high, acks delayed 10 cycles → mem_rd_o never asserted while 4 are outstanding. Ack and accept in the same cycle keep the count at 4.
- Flush with 3 in flight and 5 queued → FIFO empty, state DRAIN, the next 3 mem_ack_i produce no acc_ack_o. A read enqueued during DRAIN is issued after the third discarded ack, then IDLE.
- Error: 4 reads, second response has mem_error_i=1 → 4 acks, second with acc_data_o=0, error_o=1 until clear_i.
- Asynchronous reset asserted mid-stream (FIFO half full) → all outputs 0 immediately and busy_o=0. Re-run streaming passes.
